exec_unit: RTL
==============

Name: exec_unit

Overview:
Parametrised execute-stage unit for the pipelined MIPS-Lite core. It combines the ALU, the logical right shifter, an iterative unsigned multiplier and the HI/LO registers behind one registered result port. The iterative multiplier raises a busy/stall signal to the hazard unit, so multi-cycle ops never corrupt the pipeline. The block sits between ID/EX and EX/MEM, replacing the fixed 32-bit single-shot execute datapath.

Parameters:
DATA_W, 32, operand/result/HI/LO width; must be even and ≥8
SHAMT_W, $clog2(DATA_W), width of the shift-amount input
MUL_STEPS, DATA_W, iterations per MULTU (one bit per cycle); fixed equal to DATA_W

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
valid_in  input  1  an op is presented this cycle
ALUop  input  2  00 = ADD (lw/sw), 01 = SUB (beq), 10 = R-type (decode Funct), 11 = OR (ori)
Funct  input  6  R-type function code
shamt  input  SHAMT_W  SRL shift amount
dataA  input  DATA_W  rs operand
dataB  input  DATA_W  rt operand or extended immediate
result  output  DATA_W  registered result
result_valid  output  1  result holds a new value this cycle
busy  output  1  iterative op in flight; the hazard unit stalls IF/ID/EX
hi  output  DATA_W  HI register, debug and observation
lo  output  DATA_W  LO register, debug and observation

Behaviour:
- Reset (asynchronous): result=0, result_valid=0, busy=0, hi=0, lo=0, FSM=IDLE, iteration counter=0.
- Accept rule: an op is accepted on a rising edge when valid_in=1 and busy=0. With busy=1, inputs are ignored (no buffering); the upstream stage holds them.
- Funct codes: AND=36, OR=37, ADD=32, SUB=34, SLT=42, SRL=2, MULTU=25, MFHI=16, MFLO=18, DIVU=27 (see Optional Feature).
- Single-cycle ops (ADD, SUB, AND, OR, SLT, SRL, MFHI, MFLO, ALUop≠10): result is registered at the accept edge, and result_valid=1 for exactly the following cycle.
- ADD/SUB wrap modulo 2^DATA_W; no overflow trap.
- SLT is a signed compare, result 1 or 0.
- SRL: result = dataB >> shamt, zero fill; shamt=0 passes dataB through.
- Unknown Funct: result=0, result_valid=1.
- MULTU: unsigned DATA_W×DATA_W producing a 2·DATA_W product; HI=upper half, LO=lower half.
  - FSM IDLE→MUL on the accept edge; busy=1 from the next cycle for MUL_STEPS cycles.
  - One shift-add per cycle. At the final step edge, HI/LO are written, FSM→IDLE and busy falls.
  - result_valid stays 0 for MULTU; result holds its previous value.
- Back-to-back: an op presented in the cycle busy is low after a MULTU is accepted. MFHI/MFLO then return the new product, with no extra bubble.
- Simultaneous events: with busy=0, valid_in and a completing multiply cannot coincide, because completion implies busy was 1.
- Reset mid-operation aborts the multiply; HI/LO return to 0, not partial values.
- valid_in=0 while idle: result_valid=0, result held.

Optional Feature:
Macro EXEC_DIVU_EN.
- Defined: DIVU (Funct 27) runs a restoring unsigned divide, one quotient bit per cycle, DATA_W cycles, with the same busy timing as MULTU.
  - LO=quotient, HI=remainder.
  - Divide-by-zero: LO=all ones, HI=dataA, same latency.
- Undefined: Funct 27 is treated as unknown (result=0, result_valid=1). The divide datapath is not synthesised.

Decomposition:
- Package exec_pkg: Funct code constants, ALUop encodings, FSM state enum {IDLE, MUL, DIV}, and the default DATA_W.
- Sub-module seq_multdiv: owns the iteration counter, partial product/remainder registers and the HI/LO write. It exposes start, op select, done and busy.
- exec_unit keeps the combinational ALU/shifter, result mux and output register.

Test Plan:
- Reset asserted asynchronously mid-cycle → all outputs 0 immediately.
- ADD 0xFFFFFFFF+1 → result=0, result_valid=1 next cycle. SLT −1 vs 1 → result=1.
- SRL dataB=0x80000000, shamt=31 → result=1. shamt=0 → result=0x80000000.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → busy high 32 cycles. Then HI=0xFFFFFFFE, LO=0x00000001. MFHI issued the first non-busy cycle returns 0xFFFFFFFE.
- ADD presented while busy=1 → ignored until busy falls, then accepted. Reset at step 10 of a multiply → busy=0, hi=lo=0.
- EXEC_DIVU_EN: DIVU 100/7 → LO=14, HI=2 after 32 cycles. DIVU 5/0 → LO=0xFFFFFFFF, HI=5. Without the macro, Funct 27 → result=0, busy never asserted.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the MIPS-Lite execute stage.
// Funct codes, ALUop encodings, multiply/divide FSM states, default width.
package exec_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_e;

endpackage

// File: rtl/exec_unit_if.sv
// Operand/result bundle between ID/EX and the execute unit.
// master = upstream driver, slave = exec_unit.
interface exec_unit_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
);
    logic               valid_in;
    logic [1:0]         ALUop;
    logic [5:0]         Funct;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  dataA;
    logic [DATA_W-1:0]  dataB;
    logic [DATA_W-1:0]  result;
    logic               result_valid;
    logic               busy;
    logic [DATA_W-1:0]  hi;
    logic [DATA_W-1:0]  lo;

    modport master (
        output valid_in, ALUop, Funct, shamt, dataA, dataB,
        input  result, result_valid, busy, hi, lo
    );

    modport slave (
        input  valid_in, ALUop, Funct, shamt, dataA, dataB,
        output result, result_valid, busy, hi, lo
    );
endinterface

// File: rtl/seq_multdiv.sv
// Iterative MULTU (shift-add) and, with EXEC_DIVU_EN, restoring DIVU.
// One bit per cycle; owns the step counter, partial registers and HI/LO.
module seq_multdiv
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int STEPS  = DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CNT_W = $clog2(STEPS);

    // acc holds {partial, multiplier} or {remainder, dividend/quotient}
    md_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic                last;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_nxt;

    assign last = (cnt_q == CNT_W'(STEPS - 1));

    // one shift-add step: add multiplicand when LSB set, shift right
    always_comb begin
        mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]};
        if (acc_q[0]) begin
            mul_sum = mul_sum + {1'b0, opnd_q};
        end
        mul_nxt = {mul_sum, acc_q[DATA_W-1:1]};
    end

`ifdef EXEC_DIVU_EN
    logic [DATA_W:0]     div_shl;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] div_nxt;

    // one restoring step; a zero divisor always "fits", giving all-ones
    always_comb begin
        div_shl  = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        div_diff = div_shl - {1'b0, opnd_q};
        div_ge   = (opnd_q == '0) || !div_diff[DATA_W];
        div_nxt  = {div_ge ? div_diff[DATA_W-1:0] : div_shl[DATA_W-1:0],
                    acc_q[DATA_W-2:0], div_ge};
    end
`else
    logic op_div_unused;
    assign op_div_unused = op_div;
`endif

    // FSM next state, datapath loads and HI/LO write on the last step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = MUL;
                    opnd_d  = a;
                    acc_d   = {{DATA_W{1'b0}}, b};
`ifdef EXEC_DIVU_EN
                    if (op_div) begin
                        state_d = DIV;
                        opnd_d  = b;
                        acc_d   = {{DATA_W{1'b0}}, a};
                    end
`endif
                end
            end
            MUL: begin
                acc_d = mul_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    hi_d    = mul_nxt[2*DATA_W-1:DATA_W];
                    lo_d    = mul_nxt[DATA_W-1:0];
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef EXEC_DIVU_EN
            DIV: begin
                acc_d = div_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    hi_d    = div_nxt[2*DATA_W-1:DATA_W];
                    lo_d    = div_nxt[DATA_W-1:0];
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset aborts any op and clears HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU, SRL, HI/LO moves and iterative MULTU behind one result register.
// Define EXEC_DIVU_EN to add the iterative DIVU (Funct 27).
module exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SHAMT_W   = $clog2(DATA_W),
    parameter int MUL_STEPS = DATA_W
) (
    input  logic        clk,
    input  logic        reset,
    exec_unit_if.slave  bus
);
    logic [DATA_W-1:0] result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] hi, lo;
    logic              busy, md_done;
    logic              accept, is_r, is_mul, is_div, md_start;

    assign accept = bus.valid_in && !busy;
    assign is_r   = (bus.ALUop == ALUOP_RTYPE);
    assign is_mul = is_r && (bus.Funct == F_MULTU);
`ifdef EXEC_DIVU_EN
    assign is_div = is_r && (bus.Funct == F_DIVU);
`else
    assign is_div = 1'b0;
`endif
    assign md_start = accept && (is_mul || is_div);

    // single-cycle result: ALUop shortcuts, then R-type Funct decode
    always_comb begin
        alu_res = '0;
        case (bus.ALUop)
            ALUOP_ADD: alu_res = bus.dataA + bus.dataB;
            ALUOP_SUB: alu_res = bus.dataA - bus.dataB;
            ALUOP_OR:  alu_res = bus.dataA | bus.dataB;
            default: begin
                case (bus.Funct)
                    F_ADD:  alu_res = bus.dataA + bus.dataB;
                    F_SUB:  alu_res = bus.dataA - bus.dataB;
                    F_AND:  alu_res = bus.dataA & bus.dataB;
                    F_OR:   alu_res = bus.dataA | bus.dataB;
                    F_SLT:  alu_res = DATA_W'($signed(bus.dataA) < $signed(bus.dataB));
                    F_SRL:  alu_res = bus.dataB >> bus.shamt;
                    F_MFHI: alu_res = hi;
                    F_MFLO: alu_res = lo;
                    F_DIVU: alu_res = '0;
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

    // iterative ops leave the result register untouched
    always_comb begin
        result_d       = result_q;
        result_valid_d = 1'b0;
        if (accept && !(is_mul || is_div)) begin
            result_d       = alu_res;
            result_valid_d = 1'b1;
        end
    end

    // output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    seq_multdiv #(
        .DATA_W (DATA_W),
        .STEPS  (MUL_STEPS)
    ) u_md (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op_div (is_div),
        .a      (bus.dataA),
        .b      (bus.dataB),
        .busy   (busy),
        .done   (md_done),
        .hi     (hi),
        .lo     (lo)
    );

    logic md_done_unused;
    assign md_done_unused = md_done;

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy;
    assign bus.hi           = hi;
    assign bus.lo           = lo;

endmodule
